// File: rtl/axis_flit_egress_if.sv
// AXI-Stream egress bus carrying reassembled flit beats out of axis_flit_egress.
// A beat transfers on a rising edge where axis_tvalid and axis_tready are both 1;
// once raised, axis_tvalid stays high with tdata/tlast/tdest frozen until that edge.
interface axis_flit_egress_if #(
   parameter int DATA_WIDTH = 512,
   parameter int DEST_WIDTH = 6
);
   logic                  axis_tvalid;
   logic                  axis_tready;
   logic [DATA_WIDTH-1:0] axis_tdata;
   logic                  axis_tlast;
   logic [DEST_WIDTH-1:0] axis_tdest;

   modport master (
      output axis_tvalid,
      output axis_tdata,
      output axis_tlast,
      output axis_tdest,
      input  axis_tready
   );

   modport slave (
      input  axis_tvalid,
      input  axis_tdata,
      input  axis_tlast,
      input  axis_tdest,
      output axis_tready
   );
endinterface

// File: rtl/axis_flit_egress.sv
// Credit-governed flit receiver: buffers flits in a small FIFO, packs
// SERIALIZATION_FACTOR flits per AXI-Stream beat and returns one credit per pop.
module axis_flit_egress #(
   parameter int FLIT_WIDTH           = 128,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int DEST_WIDTH           = 6,
   parameter int FLIT_BUFFER_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FLIT_WIDTH-1:0] data_in,
   input  logic [DEST_WIDTH-1:0] dest_in,
   input  logic                  is_tail_in,
   input  logic                  send_in,
   output logic                  credit_out,
   axis_flit_egress_if.master    axis,
   output logic                  err_overflow,
   output logic                  err_tail
);

   localparam int BEAT_W  = FLIT_WIDTH * SERIALIZATION_FACTOR;
   localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam int PTR_W   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int IDX_W   = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FLIT_BUFFER_DEPTH);

   // Flit FIFO
   logic [ENTRY_W-1:0] fifo_mem [FLIT_BUFFER_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;

   logic [ENTRY_W-1:0]    head;
   logic [FLIT_WIDTH-1:0] head_data;
   logic [DEST_WIDTH-1:0] head_dest;
   logic                  head_tail;

   // Beat assembly
   logic [IDX_W-1:0]      idx;
   logic [BEAT_W-1:0]     asm_data;
   logic [DEST_WIDTH-1:0] asm_dest;
   logic                  completing;
   logic                  load;
   logic [BEAT_W-1:0]     beat_data;
   logic [DEST_WIDTH-1:0] beat_dest;

   // Output register
   logic                  out_valid;
   logic [BEAT_W-1:0]     out_data;
   logic                  out_last;
   logic [DEST_WIDTH-1:0] out_dest;
   logic                  out_free;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign push       = send_in & ~fifo_full;

   assign head      = fifo_mem[rd_ptr];
   assign head_data = head[ENTRY_W-1 -: FLIT_WIDTH];
   assign head_dest = head[DEST_WIDTH:1];
   assign head_tail = head[0];

   // A beat closes on its last slot or on an early tail; only then does the
   // pop wait for room in the output register.
   assign completing = (idx == LAST_IDX) | head_tail;
   assign out_free   = ~out_valid | axis.axis_tready;
   assign pop        = ~fifo_empty & (~completing | out_free);
   assign load       = pop & completing;

   always_comb begin
      beat_data = '0;
      for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
         if (IDX_W'(k) == idx)
            beat_data[k*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
         else if (IDX_W'(k) < idx)
            beat_data[k*FLIT_WIDTH +: FLIT_WIDTH] = asm_data[k*FLIT_WIDTH +: FLIT_WIDTH];
         else
            beat_data[k*FLIT_WIDTH +: FLIT_WIDTH] = '0;
      end
   end

   assign beat_dest = (idx == '0) ? head_dest : asm_dest;

   // Storage carries no reset; occupancy is tracked solely by the pointers/count.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         asm_data <= '0;
         asm_dest <= '0;
      end else if (pop) begin
         if (completing) begin
            idx <= '0;
         end else begin
            idx <= idx + IDX_W'(1);
            asm_data[idx*FLIT_WIDTH +: FLIT_WIDTH] <= head_data;
            if (idx == '0)
               asm_dest <= head_dest;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_dest  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= beat_data;
         out_last  <= head_tail;
         out_dest  <= beat_dest;
      end else if (axis.axis_tready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_out   <= 1'b0;
         err_overflow <= 1'b0;
         err_tail     <= 1'b0;
      end else begin
         credit_out <= pop;
         if (send_in & fifo_full)
            err_overflow <= 1'b1;
         if (load & head_tail & (idx != LAST_IDX))
            err_tail <= 1'b1;
      end
   end

   assign axis.axis_tvalid = out_valid;
   assign axis.axis_tdata  = out_data;
   assign axis.axis_tlast  = out_last;
   assign axis.axis_tdest  = out_dest;

endmodule

// File: tb/tb_axis_flit_egress.sv
// Scoreboard bench for axis_flit_egress with 8-bit flits, four flits per beat.
module tb_axis_flit_egress;

   localparam int FW = 8;
   localparam int SF = 4;
   localparam int DW = 6;
   localparam int BW = FW * SF;
   localparam int XW = BW + 1 + DW;

   logic          clk;
   logic          rst_n;
   logic [FW-1:0] data_in;
   logic [DW-1:0] dest_in;
   logic          is_tail_in;
   logic          send_in;
   logic          credit_out;
   logic          err_overflow;
   logic          err_tail;

   axis_flit_egress_if #(.DATA_WIDTH(BW), .DEST_WIDTH(DW)) axis_bus ();

   axis_flit_egress #(
      .FLIT_WIDTH(FW),
      .SERIALIZATION_FACTOR(SF),
      .DEST_WIDTH(DW),
      .FLIT_BUFFER_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data_in(data_in),
      .dest_in(dest_in),
      .is_tail_in(is_tail_in),
      .send_in(send_in),
      .credit_out(credit_out),
      .axis(axis_bus),
      .err_overflow(err_overflow),
      .err_tail(err_tail)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard state
   logic [XW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;
   int            n_credits = 0;
   bit            stalled = 1'b0;
   logic [XW-1:0] held;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && credit_out)
         n_credits++;
   end

   // Output monitor: hold-stability while stalled, scoreboard compare on transfer
   always @(negedge clk) begin
      logic [XW-1:0] cur;
      logic [XW-1:0] exp;
      cur = {axis_bus.axis_tdata, axis_bus.axis_tlast, axis_bus.axis_tdest};
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("hold_valid", 64'(axis_bus.axis_tvalid), 64'd1);
            check("hold_beat", 64'(cur), 64'(held));
         end
         if (axis_bus.axis_tvalid && axis_bus.axis_tready) begin
            if (exp_q.size() == 0) begin
               check("beat_unexpected", 64'(cur), 64'd0);
            end else begin
               exp = exp_q.pop_front();
               check("beat", 64'(cur), 64'(exp));
            end
         end
         stalled = axis_bus.axis_tvalid && !axis_bus.axis_tready;
         held    = cur;
      end
   end

   // Driver tasks; callers sit 1 time unit after a rising edge
   task automatic send_flit(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic tail);
      send_in    = 1'b1;
      data_in    = d;
      dest_in    = dst;
      is_tail_in = tail;
      @(posedge clk);
      #1;
      send_in    = 1'b0;
      is_tail_in = 1'b0;
   endtask

   task automatic send_beat(input logic [BW-1:0] d, input logic [DW-1:0] dst, input int n,
                            input bit tail_last, input bit expect_it);
      logic [BW-1:0] e;
      logic [DW-1:0] fdst;
      e = '0;
      for (int k = 0; k < n; k++)
         e[k*FW +: FW] = d[k*FW +: FW];
      if (expect_it)
         exp_q.push_back({e, 1'b1, dst});
      for (int k = 0; k < n; k++) begin
         fdst = (k == 0) ? dst : DW'($urandom_range(0, 63));
         send_flit(d[k*FW +: FW], fdst, tail_last && (k == n - 1));
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++)
         @(posedge clk);
      #1;
      check("drain", 64'(exp_q.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int            base;
      logic [BW-1:0] c_data;
      logic [DW-1:0] c_dest;

      rst_n      = 1'b0;
      send_in    = 1'b0;
      data_in    = '0;
      dest_in    = '0;
      is_tail_in = 1'b0;
      axis_bus.axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 64'(axis_bus.axis_tvalid), 64'd0);
      check("rst_tdata", 64'(axis_bus.axis_tdata), 64'd0);
      check("rst_credit", 64'(credit_out), 64'd0);
      check("rst_errs", 64'({err_overflow, err_tail}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single beat: latency and credits
      base = n_credits;
      axis_bus.axis_tready = 1'b1;
      send_beat(32'h44332211, 6'h05, 4, 1'b1, 1'b1);
      @(negedge clk);
      check("lat_early", 64'(axis_bus.axis_tvalid), 64'd0);
      @(negedge clk);
      check("lat_t2", 64'(axis_bus.axis_tvalid), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check("credits_one_beat", 64'(n_credits - base), 64'd4);
      check("drain_one_beat", 64'(exp_q.size()), 64'd0);

      // Two beats against a stalled sink
      base = n_credits;
      axis_bus.axis_tready = 1'b0;
      send_beat(BW'($urandom), DW'($urandom_range(0, 63)), 4, 1'b1, 1'b1);
      send_beat(BW'($urandom), DW'($urandom_range(0, 63)), 4, 1'b1, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      axis_bus.axis_tready = 1'b1;
      @(negedge clk);
      check("b2b_first", 64'(axis_bus.axis_tvalid), 64'd1);
      @(negedge clk);
      check("b2b_second", 64'(axis_bus.axis_tvalid), 64'd1);
      wait_drain(50);
      check("credits_two_beats", 64'(n_credits - base), 64'd8);
      check("no_errs", 64'({err_overflow, err_tail}), 64'd0);

      // Early tail after two flits
      base = n_credits;
      send_beat(32'hCCDDBBAA, 6'h2A, 2, 1'b1, 1'b1);
      wait_drain(50);
      check("err_tail_set", 64'(err_tail), 64'd1);
      check("credits_short", 64'(n_credits - base), 64'd2);
      check("no_overflow", 64'(err_overflow), 64'd0);

      // Overflow: output and assembly stalled, FIFO full, extra flit dropped
      axis_bus.axis_tready = 1'b0;
      send_beat(BW'($urandom), DW'($urandom_range(0, 63)), 4, 1'b1, 1'b1);
      send_beat(BW'($urandom), DW'($urandom_range(0, 63)), 4, 1'b1, 1'b1);
      c_data = BW'($urandom);
      c_dest = DW'($urandom_range(0, 63));
      exp_q.push_back({c_data, 1'b1, c_dest});
      for (int k = 0; k < 3; k++)
         send_flit(c_data[k*FW +: FW], (k == 0) ? c_dest : DW'($urandom_range(0, 63)), 1'b0);
      send_flit(~c_data[3*FW +: FW], DW'($urandom_range(0, 63)), 1'b0);
      @(negedge clk);
      check("overflow_set", 64'(err_overflow), 64'd1);
      axis_bus.axis_tready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      send_flit(c_data[3*FW +: FW], DW'($urandom_range(0, 63)), 1'b1);
      wait_drain(50);
      check("overflow_sticky", 64'(err_overflow), 64'd1);

      // Reset mid-beat, then a clean beat
      send_beat(32'hDEADBEEF, 6'h11, 2, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(axis_bus.axis_tvalid), 64'd0);
      check("mid_rst_beat", 64'({axis_bus.axis_tdata, axis_bus.axis_tlast, axis_bus.axis_tdest}), 64'd0);
      check("mid_rst_credit", 64'(credit_out), 64'd0);
      check("mid_rst_errs", 64'({err_overflow, err_tail}), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = n_credits;
      send_beat(32'h01020304, 6'h3C, 4, 1'b1, 1'b1);
      wait_drain(50);
      check("credits_after_rst", 64'(n_credits - base), 64'd4);
      check("errs_after_rst", 64'({err_overflow, err_tail}), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
